int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter N_SRC, default 6, giving the number of interrupt sources; it equals the CP0 HWInt width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port irq_in, input, N_SRC bits: raw device interrupt lines, asynchronous to clk.
REQ-005 The block SHALL have port addr, input, 3 bits: register word index, equal to bus byte address [4:2].
REQ-006 The block SHALL have port we, input, 1 bit: bus write strobe, sampled at the rising edge of clk.
REQ-007 The block SHALL have port wdata, input, 32 bits: bus write data.
REQ-008 The block SHALL have port rdata, output, 32 bits: combinational read data for addr.
REQ-009 The block SHALL have port HWInt, output, N_SRC bits: registered interrupt request to CP0.

Function
REQ-010 Register map: 0 PEND (R, write-1-to-clear); 1 MASK (RW); 2 MODE (RW, 1 = edge, 0 = level); 3 POL (RW, 1 = active-low); 4 INSVC (R); 5 CLAIM (R = candidate, W = claim id); 6 EOI (W = id).
REQ-011 Unused upper bits, unmapped reads and reads of EOI SHALL return 0; writes to unmapped or read-only indices are ignored.
REQ-012 Each source SHALL pass through a 2-flop synchronizer after polarity correction; s1 <= irq_in ^ POL and s2 <= s1.
REQ-013 In edge mode, PEND[i] SHALL be set on the edge where s2 = 1 and the previous s2 = 0.
REQ-014 In level mode, PEND[i] SHALL follow s2 each cycle.
REQ-015 Latency: with irq_in asserted before edge k and the source unmasked and eligible, PEND SHALL rise at edge k+2 and HWInt at edge k+3.
REQ-016 W1C to PEND SHALL clear the written bits; a set event in the same cycle wins; in level mode the bit re-sets while s2 = 1.
REQ-017 Priority: a lower index is higher priority; threshold T = index of the lowest set INSVC bit, or N_SRC if INSVC = 0.
REQ-018 The HWInt[i] register SHALL load PEND[i] & MASK[i] & ~INSVC[i] & (i < T) every cycle.
REQ-019 A CLAIM read SHALL return bit31 = valid and bits[2:0] = lowest i satisfying the REQ-018 condition; it SHALL return 0 if there is none.
REQ-020 A CLAIM write of id SHALL act only if id < N_SRC and the REQ-018 condition holds for id; it then sets INSVC[id] and clears PEND[id] in edge mode.
REQ-021 An EOI write of id SHALL clear INSVC[id]; an id with INSVC clear or id >= N_SRC is ignored.
REQ-022 MODE, MASK and POL writes SHALL take effect on the state at the next edge; HWInt reflects them one edge later.
REQ-023 A mode change from level to edge SHALL leave PEND unchanged; the first edge detection uses the current s2 history.
REQ-024 Per-source state machine: IDLE -> PENDING on PEND set; PENDING -> IDLE on W1C or level drop; PENDING -> SERVICE on CLAIM; SERVICE -> IDLE on EOI, or SERVICE -> PENDING if PEND re-set during service.
REQ-025 Nesting SHALL be permitted: a higher-priority source may be claimed while a lower one is in service; at most N_SRC levels.

Reset
REQ-026 While reset = 0, the block SHALL immediately clear s1, s2, the previous-s2 register, PEND, MASK, MODE, POL, INSVC and HWInt.
REQ-027 Reset asserted mid-service SHALL discard all in-service state; no pending event survives.
REQ-028 The first edge detection after reset release SHALL use previous-s2 = 0.

Structure
REQ-029 Register indices and N_SRC default SHALL live in the shared constants header.
REQ-030 One sub-module, int_sync, SHALL implement the synchronizer and edge detect for one source; int_ctrl instantiates it N_SRC times.
REQ-031 The priority encoder and the register file SHALL stay in int_ctrl.

Verification
REQ-032 Level source: MASK = 0x01, MODE = 0, irq_in[0] raised before edge k -> PEND = 0x01 at k+2, HWInt = 0x01 at k+3; lower the line -> HWInt = 0 three edges later.
REQ-033 Edge source 2: MASK = 0x04, MODE = 0x04, 1-cycle pulse -> PEND[2] latched; CLAIM read = 0x80000002; CLAIM write 2 -> PEND = 0, INSVC = 0x04, HWInt = 0; EOI 2 -> INSVC = 0.
REQ-034 Nesting: source 3 claimed, then source 1 pends -> HWInt = 0x02; source 4 pends -> HWInt[4] stays 0 until EOI 3.
REQ-035 Collision: W1C PEND[2] in the same cycle as a new edge on 2 -> PEND[2] remains 1.
REQ-036 Bad ids: CLAIM 5 with PEND = 0, EOI 1 with INSVC = 0, CLAIM 7 -> all state unchanged.
REQ-037 Async reset: drop reset between edges while INSVC = 0x09 and HWInt != 0 -> all registers and HWInt = 0 before the next edge.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register word indices and the
// default source count (matches the CP0 HWInt width).
package int_ctrl_pkg;

    localparam int N_SRC_DEF = 6;

    typedef enum logic [2:0] {
        REG_PEND  = 3'd0,
        REG_MASK  = 3'd1,
        REG_MODE  = 3'd2,
        REG_POL   = 3'd3,
        REG_INSVC = 3'd4,
        REG_CLAIM = 3'd5,
        REG_EOI   = 3'd6
    } reg_idx_e;

    localparam logic [31:0] CLAIM_VALID = 32'h8000_0000;

endpackage

// File: rtl/int_sync.sv
// One interrupt source: polarity correction, two-flop synchronizer and
// rising-edge detect on the synchronized level.
module int_sync (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic pol,
    output logic lvl,
    output logic rise
);

    logic s1, s2, prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= irq ^ pol;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller with nesting: per-source sync/edge detect,
// PEND/MASK/MODE/POL/INSVC register file, claim/EOI and registered HWInt.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [2:0]        addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [N_SRC-1:0]  HWInt
);

    logic [N_SRC-1:0] pend, mask, mode, pol, insvc;
    logic [N_SRC-1:0] lvl, rise;
    logic [N_SRC-1:0] allow, elig, claim_hit, eoi_hit, pend_nxt;
    logic             wr_pend, wr_mask, wr_mode, wr_pol, wr_claim, wr_eoi;
    logic             cand_vld;
    logic [2:0]       cand_id;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        int_sync u_sync (
            .clk  (clk),
            .reset(reset),
            .irq  (irq_in[gi]),
            .pol  (pol[gi]),
            .lvl  (lvl[gi]),
            .rise (rise[gi])
        );
    end

    assign wr_pend  = we && (addr == REG_PEND);
    assign wr_mask  = we && (addr == REG_MASK);
    assign wr_mode  = we && (addr == REG_MODE);
    assign wr_pol   = we && (addr == REG_POL);
    assign wr_claim = we && (addr == REG_CLAIM);
    assign wr_eoi   = we && (addr == REG_EOI);

    // allow[i]: nothing at index <= i is in service, i.e. i is below the threshold
    always_comb begin : p_allow
        logic blocked;
        blocked = 1'b0;
        allow   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked  = blocked | insvc[i];
            allow[i] = ~blocked;
        end
    end

    assign elig = pend & mask & allow;

    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                cand_vld = 1'b1;
                cand_id  = 3'(i);
            end
        end
    end

    always_comb begin
        claim_hit = '0;
        eoi_hit   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_hit[i] = wr_claim && (wdata == 32'(i)) && elig[i];
            eoi_hit[i]   = wr_eoi   && (wdata == 32'(i)) && insvc[i];
        end
    end

    // Edge sources hold until W1C or claim, with a new edge winning; level
    // sources simply track the synchronized line.
    always_comb begin
        pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode[i])
                pend_nxt[i] = rise[i] | (pend[i] & ~(wr_pend & wdata[i]) & ~claim_hit[i]);
            else
                pend_nxt[i] = lvl[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            pol   <= '0;
            insvc <= '0;
            HWInt <= '0;
        end else begin
            pend  <= pend_nxt;
            if (wr_mask) mask <= wdata[N_SRC-1:0];
            if (wr_mode) mode <= wdata[N_SRC-1:0];
            if (wr_pol)  pol  <= wdata[N_SRC-1:0];
            insvc <= (insvc | claim_hit) & ~eoi_hit;
            HWInt <= elig;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_PEND:  rdata[N_SRC-1:0] = pend;
            REG_MASK:  rdata[N_SRC-1:0] = mask;
            REG_MODE:  rdata[N_SRC-1:0] = mode;
            REG_POL:   rdata[N_SRC-1:0] = pol;
            REG_INSVC: rdata[N_SRC-1:0] = insvc;
            REG_CLAIM: rdata = cand_vld ? (CLAIM_VALID | {29'b0, cand_id}) : '0;
            default:   rdata = '0;
        endcase
    end

endmodule
